// File: rtl/async_dual_port_8_16.sv
// rtl/async_dual_port_8_16.sv - 8x16 simple dual-port RAM with registered read port
//
// Purpose:
//   Register-file style buffer between a producer that writes by address
//   and a consumer that reads by address. Both ports share one clock.
//   Reads have one cycle of latency, and read data is registered.
//   A read and a write to the same address in the same cycle return the
//   incoming write data (write-first).
//
// Ports:
//   clk      in   single clock, all state updates on the rising edge
//   rst      in   synchronous active-high reset; clears memory, dout and rd_valid
//   we       in   write enable
//   wr_addr  in   write address [ADDR_W-1:0]
//   din      in   write data [DATA_W-1:0]
//   re       in   read enable
//   rd_addr  in   read address [ADDR_W-1:0]
//   dout     out  registered read data [DATA_W-1:0]; holds while re is low
//   rd_valid out  high for the one cycle after an accepted read

module async_dual_port_8_16 #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] din,
    input  logic              re,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] dout,
    output logic              rd_valid
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_word;
    logic              collide;

    // Same-address read and write in one cycle forward the new data so
    // the consumer never sees the stale word.
    always_comb begin
        collide = we && (wr_addr == rd_addr);
        rd_word = collide ? din : mem[rd_addr];
    end

    // Reset clears every word, so the memory is held in flops rather
    // than an inferred RAM macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wr_addr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout     <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= re;
            if (re) begin
                dout <= rd_word;
            end
        end
    end

endmodule

// File: tb/tb_async_dual_port_8_16.sv
// tb/tb_async_dual_port_8_16.sv - scoreboard bench for async_dual_port_8_16

module tb_async_dual_port_8_16;

    logic        clk;
    logic        rst;
    logic        we;
    logic [2:0]  wr_addr;
    logic [15:0] din;
    logic        re;
    logic [2:0]  rd_addr;
    logic [15:0] dout;
    logic        rd_valid;

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_q [$];
    string       name_q [$];

    async_dual_port_8_16 #(.DATA_W(16), .ADDR_W(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .wr_addr  (wr_addr),
        .din      (din),
        .re       (re),
        .rd_addr  (rd_addr),
        .dout     (dout),
        .rd_valid (rd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // Monitor: every valid read result is matched against the oldest
    // expectation pushed by the stimulus.
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_rd_valid: got dout=%h with rd_valid=1, required no read result", dout);
            end else begin
                logic [15:0] e;
                string       n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                if (dout !== e) begin
                    bad++;
                    $display("FAIL %s: got dout=%h, required %h", n, dout, e);
                end
            end
        end
    end

    task automatic check(input string n, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, required %h", n, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        we = 1'b0;
        re = 1'b0;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [15:0] d);
        we = 1'b1; wr_addr = a; din = d;
        tick();
    endtask

    task automatic do_read(input string n, input logic [2:0] a, input logic [15:0] e);
        re = 1'b1; rd_addr = a;
        exp_q.push_back(e); name_q.push_back(n);
        tick();
    endtask

    task automatic do_both(input string n, input logic [2:0] wa, input logic [15:0] d,
                           input logic [2:0] ra, input logic [15:0] e);
        we = 1'b1; wr_addr = wa; din = d;
        re = 1'b1; rd_addr = ra;
        exp_q.push_back(e); name_q.push_back(n);
        tick();
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; re = 1'b0;
        wr_addr = '0; rd_addr = '0; din = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("reset_dout", dout, 16'h0000);
        check("reset_rd_valid", {15'd0, rd_valid}, 16'h0000);

        for (int k = 0; k < 8; k++) do_read("reset_read", 3'(k), 16'h0000);

        for (int k = 0; k < 8; k++) do_write(3'(k), 16'(k));
        for (int k = 0; k < 8; k++) do_read("sweep_read", 3'(k), 16'(k));

        do_write(3'd1, 16'd1);
        do_read("interleave_read", 3'd1, 16'd1);
        tick();
        check("hold_dout", dout, 16'd1);
        check("hold_rd_valid", {15'd0, rd_valid}, 16'h0000);

        do_write(3'd3, 16'h00AA);
        do_both("collide_read", 3'd3, 16'h1234, 3'd3, 16'h1234);
        do_read("collide_reread", 3'd3, 16'h1234);

        do_both("diff_read5", 3'd6, 16'hBEEF, 3'd5, 16'd5);
        do_read("diff_read6", 3'd6, 16'hBEEF);

        for (int k = 0; k < 8; k++) do_write(3'(k), 16'h1000 + 16'(k));
        do_read("prefill_read2", 3'd2, 16'h1002);
        rst = 1'b1;
        we = 1'b1; wr_addr = 3'd2; din = 16'hFFFF;
        re = 1'b1; rd_addr = 3'd2;
        tick();
        rst = 1'b0;
        check("midreset_dout", dout, 16'h0000);
        check("midreset_rd_valid", {15'd0, rd_valid}, 16'h0000);
        do_read("post_reset_read2", 3'd2, 16'h0000);
        do_read("post_reset_read7", 3'd7, 16'h0000);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        check("queue_drained", 16'(exp_q.size()), 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
